// File: rtl/sar_pkg.sv
// Shared types and helpers for the differential SAR core.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONV,
    DONE
  } sar_state_t;

  localparam int unsigned DEF_ADC_BITS = 8;
  localparam int unsigned CNT_W        = $clog2(DEF_ADC_BITS + 1);

  // Unit-cap multiple of binary cap i (i = 1 is the MSB cap).
  function automatic int unsigned cap_weight(input int unsigned i, input int unsigned bits);
    return 32'd1 << (bits - 1 - i);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/sar_cap_half.sv
// One single-ended capacitor DAC half: sampled top-plate charge plus switched bottom plates.
// Cap index 0 is the shield cap (never switched); indices 1..ADC_BITS-1 are binary caps.
// Optional feature: CAP_MISMATCH_EN scales every cap by a random factor fixed at time 0.
module sar_cap_half
  import sar_pkg::*;
#(
  parameter int unsigned ADC_BITS       = 8,
  parameter real         DAC_CAP        = 1.0e-15,
  parameter real         PAR_CAP        = 0.0,
  parameter real         MISMATCH_SIGMA = 0.01,
  parameter int          SEED           = 1
) (
  input  logic [ADC_BITS-2:0] sw,
  input  real                 vs,
  input  real                 vrefp,
  input  real                 vrefn,
  output real                 vtop
);

  function automatic real ideal_cap(input int unsigned i);
    return DAC_CAP * real'((i == 0) ? 1 : cap_weight(i, ADC_BITS));
  endfunction

  real                 csw;
  real                 ctot;
  logic [ADC_BITS-2:0] sw_bits;

`ifdef CAP_MISMATCH_EN
  real cap_mm [ADC_BITS];

  // Freeze one mismatch draw per cap at time zero; sd scaled by 1000 to keep resolution.
  initial begin
    int seed_v;
    seed_v = SEED;
    for (int unsigned i = 0; i < ADC_BITS; i++) begin
      cap_mm[i] = ideal_cap(i) *
                  (1.0 + MISMATCH_SIGMA * real'($dist_normal(seed_v, 0, 1000)) / 1000.0);
    end
  end
`endif

  // Top plate keeps its sampled charge; each switched plate pulls it down by its share of Ctot.
  always_comb begin
    csw     = 0.0;
    ctot    = PAR_CAP;
    sw_bits = sw;
    for (int unsigned i = 0; i < ADC_BITS; i++) begin
`ifdef CAP_MISMATCH_EN
      ctot = ctot + cap_mm[i];
`else
      ctot = ctot + ideal_cap(i);
`endif
    end
    for (int unsigned j = 0; j < ADC_BITS - 1; j++) begin
      if (sw_bits[0]) begin
`ifdef CAP_MISMATCH_EN
        csw = csw + cap_mm[j+1];
`else
        csw = csw + ideal_cap(j + 1);
`endif
      end
      sw_bits = sw_bits >> 1;
    end
    vtop = vs - (vrefp - vrefn) * csw / ctot;
  end

endmodule

// File: rtl/sar_diff_capdac_ctrl.sv
// Differential SAR core: sample/convert FSM, monotonic switch control, result register,
// and two cap-DAC halves feeding an external comparator.
// Optional feature: define CAP_MISMATCH_EN to enable random cap mismatch in both halves.
module sar_diff_capdac_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned ADC_BITS       = 8,
  parameter real         DAC_CAP        = 1.0e-15,
  parameter real         PAR_CAP        = 0.0,
  parameter int unsigned SAMPLE_CYCLES  = 2,
  parameter real         MISMATCH_SIGMA = 0.01,
  parameter int          SEED           = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  real                 vip,
  input  real                 vin,
  input  real                 vrefp,
  input  real                 vrefn,
  input  logic                comp,
  output real                 vop,
  output real                 von,
  output logic [ADC_BITS-1:0] dout,
  output logic                valid,
  output logic                busy
);

  localparam int unsigned SwW  = ADC_BITS - 1;
  localparam int unsigned CntW = cnt_width(ADC_BITS);
  localparam int unsigned SmpW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  localparam logic [CntW-1:0] BitLast = CntW'(ADC_BITS - 1);
  localparam logic [SmpW-1:0] SmpLast = SmpW'(SAMPLE_CYCLES - 1);

  sar_state_t          state_q, state_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SmpW-1:0]     smp_cnt_q, smp_cnt_d;
  logic [ADC_BITS-1:0] res_q, res_d;
  logic [ADC_BITS-1:0] dout_q, dout_d;
  logic [SwW-1:0]      sw_p_q, sw_p_d;
  logic [SwW-1:0]      sw_n_q, sw_n_d;
  logic [SwW-1:0]      step_mask;
  real                 vsp_q, vsp_d;
  real                 vsn_q, vsn_d;
  real                 vtop_p, vtop_n;
  logic                comp_bit;

  // An unresolved comparator decision counts as "P not above N".
  assign comp_bit = $isunknown(comp) ? 1'b0 : comp;

  // Next-state logic: sequencing, sampling, one switch per decision, result capture.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    smp_cnt_d = smp_cnt_q;
    res_d     = res_q;
    dout_d    = dout_q;
    sw_p_d    = sw_p_q;
    sw_n_d    = sw_n_q;
    vsp_d     = vsp_q;
    vsn_d     = vsn_q;
    // Shifts out to zero on the last step, so the final decision switches nothing.
    step_mask = SwW'(1) << bit_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SAMPLE;
          smp_cnt_d = '0;
          sw_p_d    = '0;
          sw_n_d    = '0;
        end
      end
      SAMPLE: begin
        vsp_d = vip;
        vsn_d = vin;
        if (smp_cnt_q == SmpLast) begin
          state_d   = CONV;
          bit_cnt_d = '0;
        end else begin
          smp_cnt_d = smp_cnt_q + SmpW'(1);
        end
      end
      CONV: begin
        res_d = {res_q[ADC_BITS-2:0], comp_bit};
        if (comp_bit) begin
          sw_p_d = sw_p_q | step_mask;
        end else begin
          sw_n_d = sw_n_q | step_mask;
        end
        if (bit_cnt_q == BitLast) begin
          state_d = DONE;
          dout_d  = {res_q[ADC_BITS-2:0], comp_bit};
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any conversion without a valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      smp_cnt_q <= '0;
      res_q     <= '0;
      dout_q    <= '0;
      sw_p_q    <= '0;
      sw_n_q    <= '0;
      vsp_q     <= 0.0;
      vsn_q     <= 0.0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      res_q     <= res_d;
      dout_q    <= dout_d;
      sw_p_q    <= sw_p_d;
      sw_n_q    <= sw_n_d;
      vsp_q     <= vsp_d;
      vsn_q     <= vsn_d;
    end
  end

`ifndef SYNTHESIS
  // Flag unresolved comparator decisions seen during conversion.
  always_ff @(posedge clk) begin
    if (!reset && state_q == CONV && $isunknown(comp)) begin
      $display("sar_diff_capdac_ctrl: warning, comp unknown at step %0d, bit forced 0",
               bit_cnt_q);
    end
  end
`endif

  sar_cap_half #(
    .ADC_BITS       (ADC_BITS),
    .DAC_CAP        (DAC_CAP),
    .PAR_CAP        (PAR_CAP),
    .MISMATCH_SIGMA (MISMATCH_SIGMA),
    .SEED           (SEED)
  ) u_cap_p (
    .sw    (sw_p_q),
    .vs    (vsp_q),
    .vrefp (vrefp),
    .vrefn (vrefn),
    .vtop  (vtop_p)
  );

  // Distinct seed so the two halves draw independent mismatch.
  sar_cap_half #(
    .ADC_BITS       (ADC_BITS),
    .DAC_CAP        (DAC_CAP),
    .PAR_CAP        (PAR_CAP),
    .MISMATCH_SIGMA (MISMATCH_SIGMA),
    .SEED           (SEED + 7919)
  ) u_cap_n (
    .sw    (sw_n_q),
    .vs    (vsn_q),
    .vrefp (vrefp),
    .vrefn (vrefn),
    .vtop  (vtop_n)
  );

  // Top plates follow the inputs while tracking, otherwise the DAC charge-share result.
  assign vop   = (state_q == SAMPLE) ? vip : vtop_p;
  assign von   = (state_q == SAMPLE) ? vin : vtop_n;
  assign dout  = dout_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sar_diff_capdac_ctrl.sv
// Directed bench for sar_diff_capdac_ctrl: 8-bit, vrefp=1.0, vrefn=0.0, vin=0.5, ideal comparator.
module tb_sar_diff_capdac_ctrl;

  localparam real Tol = 1.0e-9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  real        vip = 0.5;
  real        vin = 0.5;
  real        vrefp = 1.0;
  real        vrefn = 0.0;
  logic       comp;
  real        vop;
  real        von;
  logic [7:0] dout;
  logic       valid;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Ideal comparator, strict greater-than.
  assign comp = (vop > von);

  sar_diff_capdac_ctrl #(
    .ADC_BITS      (8),
    .SAMPLE_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .vip   (vip),
    .vin   (vin),
    .vrefp (vrefp),
    .vrefn (vrefn),
    .comp  (comp),
    .vop   (vop),
    .von   (von),
    .dout  (dout),
    .valid (valid),
    .busy  (busy)
  );

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  // Start a conversion and wait for valid; edges counts posedges from the one that takes start.
  task automatic convert(input real v, output logic [7:0] code, output int edges);
    vip = v;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (valid !== 1'b1 && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    code = dout;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++;
    if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else n_pass++;
    n_checks++;
    if (rabs(vop) > Tol) $display("FAIL reset_vop: got %f want 0.0", vop); else n_pass++;
    n_checks++;
    if (rabs(von) > Tol) $display("FAIL reset_von: got %f want 0.0", von); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_conv_c0;
    int n;
    vip = 1.002;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL c0_busy_start: got %b want 1", busy); else n_pass++;
    while (valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != 11) $display("FAIL c0_latency: got %0d clocks want 11", n); else n_pass++;
    n_checks++;
    if (dout !== 8'hC0) $display("FAIL c0_dout: got %h want c0", dout); else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL c0_busy_done: got %b want 1", busy); else n_pass++;
    n_checks++;
    if (rabs((vop - von) - (0.002 - 0.0078125)) > Tol)
      $display("FAIL c0_residue: got %f want %f", vop - von, 0.002 - 0.0078125);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL c0_valid_pulse: got %b want 0", valid); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL c0_busy_idle: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (dout !== 8'hC0) $display("FAIL c0_dout_hold: got %h want c0", dout); else n_pass++;
  endtask

  task automatic test_equal_inputs;
    int n;
    vip = 0.5;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    repeat (2) @(posedge clk);
    #1;
    n = 3;
    n_checks++;
    if (rabs(von - 0.5) > Tol) $display("FAIL eq_von_sampled: got %f want 0.5", von); else n_pass++;
    @(posedge clk);
    #1;
    n = 4;
    n_checks++;
    if (rabs(von - 0.0) > Tol) $display("FAIL eq_von_msb: got %f want 0.0", von); else n_pass++;
    n_checks++;
    if (rabs(vop - 0.5) > Tol) $display("FAIL eq_vop_msb: got %f want 0.5", vop); else n_pass++;
    while (valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != 11) $display("FAIL eq_latency: got %0d clocks want 11", n); else n_pass++;
    n_checks++;
    if (dout !== 8'h7F) $display("FAIL eq_dout: got %h want 7f", dout); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_overrange;
    logic [7:0] code;
    int         n;
    convert(1.6, code, n);
    n_checks++;
    if (code !== 8'hFF) $display("FAIL ovr_dout: got %h want ff", code); else n_pass++;
    n_checks++;
    if (rabs(von - 0.5) > Tol) $display("FAIL ovr_von: got %f want 0.5", von); else n_pass++;
    n_checks++;
    if (rabs(vop - (1.6 - 127.0 / 128.0)) > Tol)
      $display("FAIL ovr_vop: got %f want %f", vop, 1.6 - 127.0 / 128.0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_conv;
    int pulses;
    vip = 1.002;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (dout !== 8'hFF) $display("FAIL rm_dout_held: got %h want ff", dout); else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rm_busy_conv: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (dout !== 8'h00) $display("FAIL rm_dout: got %h want 00", dout); else n_pass++;
    n_checks++;
    if (rabs(vop) > Tol) $display("FAIL rm_vop: got %f want 0.0", vop); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL rm_no_valid: got %0d pulses want 0", pulses); else n_pass++;
  endtask

  task automatic test_ramp;
    logic [7:0] code;
    logic [7:0] prev;
    int         n;
    int         expv;
    real        vd;
    real        x;
    prev = 8'h00;
    for (int i = 0; i < 26; i++) begin
      vd = -0.99 + 0.0777 * i;
      x = (vd + 1.0) * 128.0;
      expv = int'($ceil(x)) - 1;
      if (expv < 0) expv = 0;
      if (expv > 255) expv = 255;
      convert(0.5 + vd, code, n);
      n_checks++;
      if (code !== expv[7:0]) $display("FAIL ramp_code[%0d]: got %h want %h", i, code, expv[7:0]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (code < prev) $display("FAIL ramp_mono[%0d]: got %h after %h", i, code, prev);
        else n_pass++;
      end
      prev = code;
    end
  endtask

  task automatic test_back_to_back;
    logic valid_at [1:30];
    logic busy_at  [1:30];
    int   pulses;
    vip = 1.002;
    @(negedge clk);
    start = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      valid_at[e] = valid;
      busy_at[e]  = busy;
    end
    start = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 30; e++) if (valid_at[e] === 1'b1) pulses++;
    n_checks++;
    if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else n_pass++;
    n_checks++;
    if (valid_at[11] !== 1'b1) $display("FAIL b2b_valid1: got %b want 1", valid_at[11]);
    else n_pass++;
    n_checks++;
    if (valid_at[23] !== 1'b1) $display("FAIL b2b_valid2: got %b want 1", valid_at[23]);
    else n_pass++;
    n_checks++;
    if (busy_at[12] !== 1'b0) $display("FAIL b2b_idle_gap: got %b want 0", busy_at[12]);
    else n_pass++;
    n_checks++;
    if (busy_at[13] !== 1'b1) $display("FAIL b2b_resample: got %b want 1", busy_at[13]);
    else n_pass++;
    n_checks++;
    if (busy_at[24] !== 1'b0) $display("FAIL b2b_idle_gap2: got %b want 0", busy_at[24]);
    else n_pass++;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_conv_c0();
    test_equal_inputs();
    test_overrange();
    test_reset_mid_conv();
    test_ramp();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
